// File: rtl/pc_pkg.sv
// Next-PC operation codes shared by the Control Unit and the program counter.
package pc_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] pc_op_t;

  localparam pc_op_t OP_NEXT   = 3'd0;
  localparam pc_op_t OP_JUMP   = 3'd1;
  localparam pc_op_t OP_BRANCH = 3'd2;
  localparam pc_op_t OP_CALL   = 3'd3;
  localparam pc_op_t OP_RET    = 3'd4;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: DEPTH entries of DATA_W bits, push/pop ignored when full/empty.
module ret_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] mem [DEPTH];

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Entries are not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (reset && push && !full) begin
      mem[IDX_W'(sp)] <= din;
    end
  end

  assign dout = empty ? '0 : mem[IDX_W'(sp - 1'b1)];

endmodule

// File: rtl/pc_stack.sv
// Program counter with next/jump/branch/call/ret, stall input and sticky
// return-stack fault flags.
module pc_stack
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  pc_op_t            op,
  input  logic [ADDR_W-1:0] new_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign addr_inc = addr + 1'b1;

  ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .dout  (ret_addr),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_comb begin
    next_addr = addr_inc;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (op)
      OP_JUMP:   next_addr = new_addr;
      // Offset has the PC's width, so plain modular add equals sign-extended add.
      OP_BRANCH: next_addr = addr + new_addr;
      OP_CALL: begin
        if (stack_full) begin
          set_ovf   = en;
          next_addr = addr;
        end else begin
          push      = en;
          next_addr = new_addr;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          set_unf = en;
        end else begin
          pop       = en;
          next_addr = ret_addr;
        end
      end
      default: next_addr = addr_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= RESET_ADDR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      addr      <= next_addr;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack with hand-computed expectations.
module tb_pc_stack;
  import pc_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  pc_op_t     op;
  logic [7:0] new_addr;
  logic [7:0] addr;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  pc_stack #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .new_addr    (new_addr),
    .addr        (addr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic e, input pc_op_t o, input logic [7:0] a);
    en = e; op = o; new_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle(1'b1, OP_CALL, 8'hAA);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", addr); end
    checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL reset_stack: empty=%b full=%b want 1 0", stack_empty, stack_full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf=%b unf=%b want 0 0", overflow, underflow); end
  endtask

  task automatic test_next();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, OP_NEXT, 8'h00);
      checks++; if (addr !== 8'(i)) begin errors++; $display("FAIL next_%0d: got %h want %h", i, addr, 8'(i)); end
    end
    checks++; if (stack_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL next_flags: empty=%b ovf=%b unf=%b want 1 0 0", stack_empty, overflow, underflow); end
  endtask

  task automatic test_wrap_stall();
    cycle(1'b1, OP_JUMP, 8'hFF);
    checks++; if (addr !== 8'hFF) begin errors++; $display("FAIL jump_ff: got %h want ff", addr); end
    cycle(1'b1, OP_NEXT, 8'h00);
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL wrap: got %h want 00", addr); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, OP_JUMP, 8'h55);
      checks++; if (addr !== 8'h00) begin errors++; $display("FAIL stall_%0d: got %h want 00", i, addr); end
    end
  endtask

  task automatic test_branch();
    cycle(1'b1, OP_JUMP, 8'h10);
    cycle(1'b1, OP_BRANCH, 8'hFC);
    checks++; if (addr !== 8'h0C) begin errors++; $display("FAIL branch_back: got %h want 0c", addr); end
    cycle(1'b1, OP_JUMP, 8'h02);
    cycle(1'b1, OP_BRANCH, 8'hFC);
    checks++; if (addr !== 8'hFE) begin errors++; $display("FAIL branch_wrap: got %h want fe", addr); end
    cycle(1'b1, OP_BRANCH, 8'h05);
    checks++; if (addr !== 8'h03) begin errors++; $display("FAIL branch_fwd: got %h want 03", addr); end
  endtask

  task automatic test_reserved();
    cycle(1'b1, OP_JUMP, 8'h40);
    cycle(1'b1, 3'd5, 8'h99);
    checks++; if (addr !== 8'h41) begin errors++; $display("FAIL reserved_5: got %h want 41", addr); end
    cycle(1'b1, 3'd7, 8'h99);
    checks++; if (addr !== 8'h42) begin errors++; $display("FAIL reserved_7: got %h want 42", addr); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || stack_empty !== 1'b1) begin errors++; $display("FAIL reserved_flags: ovf=%b unf=%b empty=%b want 0 0 1", overflow, underflow, stack_empty); end
  endtask

  task automatic test_nested_call();
    cycle(1'b1, OP_JUMP, 8'h20);
    cycle(1'b1, OP_CALL, 8'h40);
    checks++; if (addr !== 8'h40 || stack_empty !== 1'b0) begin errors++; $display("FAIL call_1: addr=%h empty=%b want 40 0", addr, stack_empty); end
    cycle(1'b1, OP_CALL, 8'h60);
    checks++; if (addr !== 8'h60 || stack_full !== 1'b0) begin errors++; $display("FAIL call_2: addr=%h full=%b want 60 0", addr, stack_full); end
    cycle(1'b0, OP_RET, 8'h00);
    checks++; if (addr !== 8'h60) begin errors++; $display("FAIL ret_stall: got %h want 60", addr); end
    cycle(1'b1, OP_RET, 8'h00);
    checks++; if (addr !== 8'h41) begin errors++; $display("FAIL ret_1: got %h want 41", addr); end
    cycle(1'b1, OP_RET, 8'h00);
    checks++; if (addr !== 8'h21) begin errors++; $display("FAIL ret_2: got %h want 21", addr); end
    checks++; if (stack_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL nest_flags: empty=%b ovf=%b unf=%b want 1 0 0", stack_empty, overflow, underflow); end
  endtask

  task automatic test_faults();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h29, 8'h21, 8'h11, 8'h01};
    do_reset();
    cycle(1'b1, OP_CALL, 8'h10);
    cycle(1'b1, OP_CALL, 8'h20);
    cycle(1'b1, OP_CALL, 8'h28);
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL full_at_3: got %b want 0", stack_full); end
    cycle(1'b1, OP_CALL, 8'h30);
    checks++; if (stack_full !== 1'b1 || addr !== 8'h30) begin errors++; $display("FAIL full_at_4: full=%b addr=%h want 1 30", stack_full, addr); end
    cycle(1'b1, OP_CALL, 8'h70);
    checks++; if (overflow !== 1'b1 || addr !== 8'h30 || stack_full !== 1'b1) begin errors++; $display("FAIL overflow: ovf=%b addr=%h full=%b want 1 30 1", overflow, addr, stack_full); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, OP_RET, 8'h00);
      checks++; if (addr !== exp_ret[i]) begin errors++; $display("FAIL fault_ret_%0d: got %h want %h", i, addr, exp_ret[i]); end
    end
    checks++; if (underflow !== 1'b0 || stack_empty !== 1'b1) begin errors++; $display("FAIL pre_underflow: unf=%b empty=%b want 0 1", underflow, stack_empty); end
    cycle(1'b1, OP_RET, 8'h00);
    checks++; if (underflow !== 1'b1 || addr !== 8'h02) begin errors++; $display("FAIL underflow: unf=%b addr=%h want 1 02", underflow, addr); end
    for (int i = 0; i < 10; i++) cycle(1'b1, OP_NEXT, 8'h00);
    checks++; if (addr !== 8'h0C) begin errors++; $display("FAIL persist_addr: got %h want 0c", addr); end
    checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL persist_flags: ovf=%b unf=%b want 1 1", overflow, underflow); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, OP_JUMP, 8'h50);
    cycle(1'b1, OP_CALL, 8'h60);
    cycle(1'b1, OP_CALL, 8'h70);
    do_reset();
    checks++; if (addr !== 8'h00 || stack_empty !== 1'b1) begin errors++; $display("FAIL mid_reset: addr=%h empty=%b want 00 1", addr, stack_empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: ovf=%b unf=%b want 0 0", overflow, underflow); end
    cycle(1'b1, OP_RET, 8'h00);
    checks++; if (underflow !== 1'b1 || addr !== 8'h01) begin errors++; $display("FAIL mid_reset_ret: unf=%b addr=%h want 1 01", underflow, addr); end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; op = OP_NEXT; new_addr = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_next();
    test_wrap_stall();
    test_branch();
    test_reserved();
    test_nested_call();
    test_faults();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
